syn_fft_bfly: RTL

- Pipelined radix-2 DIT FFT butterfly; the RTL datapath that the team's complex mul/add/sub verification model predicts.
- Computes x0 = a + b·t and x1 = a − b·t.
  - Samples are signed complex integers.
  - Twiddles are signed Q(TWDL_W−9).8 fixed point, so 256 represents 1.0.
- Sits between the FFT sample RAM read port and the write-back path.
- Bit-exact with the scoreboard model.

---
 rtl/syn_fft_bfly.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/syn_fft_bfly.sv
// syn_fft_bfly - pipelined radix-2 DIT FFT butterfly
//
// Computes x0 = a + b*t and x1 = a - b*t on signed complex integer samples.
// Twiddles are signed fixed point with 8 fractional bits (256 == 1.0).
// Three register stages share one advance signal, so bubbles are carried
// through the pipe and backpressure stalls every stage at once.
//
// Optional feature macro: SYN_FFT_BFLY_SAT_EN
//   defined   : m (stage 2) and x0/x1 (stage 3) saturate; clamps set sticky ovf
//   undefined : all reductions wrap modulo 2^SAMPLE_W; ovf tied 0
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_vld / in_rdy          input beat handshake
//   a_re, a_im, b_re, b_im   butterfly operands (SAMPLE_W, two's complement)
//   t_re, t_im               twiddle (TWDL_W, 8 fractional bits)
//   out_vld / out_rdy        result handshake
//   x0_re, x0_im             a + b*t
//   x1_re, x1_im             a - b*t
//   ovf, ovf_clr             sticky saturation flag and its clear
module syn_fft_bfly #(
    parameter int SAMPLE_W = 16,
    parameter int TWDL_W   = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic signed [SAMPLE_W-1:0] a_re,
    input  logic signed [SAMPLE_W-1:0] a_im,
    input  logic signed [SAMPLE_W-1:0] b_re,
    input  logic signed [SAMPLE_W-1:0] b_im,
    input  logic signed [TWDL_W-1:0]   t_re,
    input  logic signed [TWDL_W-1:0]   t_im,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic signed [SAMPLE_W-1:0] x0_re,
    output logic signed [SAMPLE_W-1:0] x0_im,
    output logic signed [SAMPLE_W-1:0] x1_re,
    output logic signed [SAMPLE_W-1:0] x1_im,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int PW  = SAMPLE_W + TWDL_W;
    localparam int FW  = PW + 1;
    localparam int SW1 = SAMPLE_W + 1;

    logic                       w_adv;
    logic                       r_v1, r_v2, r_v3;
    logic signed [PW-1:0]       r_pr, r_pi, r_qr, r_qi;
    logic signed [SAMPLE_W-1:0] r_a1_re, r_a1_im, r_a2_re, r_a2_im;
    logic signed [SAMPLE_W-1:0] r_m_re, r_m_im;
    logic signed [SAMPLE_W-1:0] r_x0_re, r_x0_im, r_x1_re, r_x1_im;

    // The whole pipe moves together whenever the output slot is empty or drained.
    assign w_adv   = !r_v3 || out_rdy;
    assign in_rdy  = w_adv;
    assign out_vld = r_v3;
    assign x0_re   = r_x0_re;
    assign x0_im   = r_x0_im;
    assign x1_re   = r_x1_re;
    assign x1_im   = r_x1_im;

    // Stage 1 operands are sign-extended to the full product width first so the
    // multiplies are exact.
    logic signed [PW-1:0] w_b_re_x, w_b_im_x, w_t_re_x, w_t_im_x;
    logic signed [PW-1:0] w_pr, w_pi, w_qr, w_qi;

    assign w_b_re_x = {{TWDL_W{b_re[SAMPLE_W-1]}}, b_re};
    assign w_b_im_x = {{TWDL_W{b_im[SAMPLE_W-1]}}, b_im};
    assign w_t_re_x = {{SAMPLE_W{t_re[TWDL_W-1]}}, t_re};
    assign w_t_im_x = {{SAMPLE_W{t_im[TWDL_W-1]}}, t_im};
    assign w_pr     = w_b_re_x * w_t_re_x;
    assign w_pi     = w_b_im_x * w_t_im_x;
    assign w_qr     = w_b_re_x * w_t_im_x;
    assign w_qi     = w_b_im_x * w_t_re_x;

    // Stage 1 register: partial products and the delayed a operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_pr    <= '0;
            r_pi    <= '0;
            r_qr    <= '0;
            r_qi    <= '0;
            r_a1_re <= '0;
            r_a1_im <= '0;
        end else if (w_adv) begin
            r_v1    <= in_vld;
            r_pr    <= w_pr;
            r_pi    <= w_pi;
            r_qr    <= w_qr;
            r_qi    <= w_qi;
            r_a1_re <= a_re;
            r_a1_im <= a_im;
        end
    end

    // Division by 256 must truncate toward zero, so negative values get a
    // +255 bias before the arithmetic shift (a bare shift would floor).
    logic signed [FW-1:0] w_mre_full, w_mim_full, w_mre_adj, w_mim_adj;
    logic signed [FW-1:0] w_mre_div, w_mim_div;

    assign w_mre_full = {r_pr[PW-1], r_pr} - {r_pi[PW-1], r_pi};
    assign w_mim_full = {r_qr[PW-1], r_qr} + {r_qi[PW-1], r_qi};
    assign w_mre_adj  = w_mre_full[FW-1] ? w_mre_full + FW'(255) : w_mre_full;
    assign w_mim_adj  = w_mim_full[FW-1] ? w_mim_full + FW'(255) : w_mim_full;
    assign w_mre_div  = w_mre_adj >>> 8;
    assign w_mim_div  = w_mim_adj >>> 8;

    logic signed [SAMPLE_W-1:0] w_m_re, w_m_im;
    logic signed [SW1-1:0]      w_x0_re_full, w_x0_im_full, w_x1_re_full, w_x1_im_full;
    logic signed [SAMPLE_W-1:0] w_x0_re, w_x0_im, w_x1_re, w_x1_im;

    assign w_x0_re_full = {r_a2_re[SAMPLE_W-1], r_a2_re} + {r_m_re[SAMPLE_W-1], r_m_re};
    assign w_x0_im_full = {r_a2_im[SAMPLE_W-1], r_a2_im} + {r_m_im[SAMPLE_W-1], r_m_im};
    assign w_x1_re_full = {r_a2_re[SAMPLE_W-1], r_a2_re} - {r_m_re[SAMPLE_W-1], r_m_re};
    assign w_x1_im_full = {r_a2_im[SAMPLE_W-1], r_a2_im} - {r_m_im[SAMPLE_W-1], r_m_im};

`ifdef SYN_FFT_BFLY_SAT_EN
    localparam logic [SAMPLE_W-1:0] MAXV = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] MINV = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // A value fits in SAMPLE_W bits when every bit above the target sign bit
    // matches it.
    function automatic logic fitsM(input logic [FW-1:0] v);
        return (&v[FW-1:SAMPLE_W-1]) | ~(|v[FW-1:SAMPLE_W-1]);
    endfunction

    function automatic logic [SAMPLE_W-1:0] clampM(input logic [FW-1:0] v);
        if (fitsM(v)) return v[SAMPLE_W-1:0];
        return v[FW-1] ? MINV : MAXV;
    endfunction

    function automatic logic fitsS(input logic [SW1-1:0] v);
        return v[SW1-1] == v[SAMPLE_W-1];
    endfunction

    function automatic logic [SAMPLE_W-1:0] clampS(input logic [SW1-1:0] v);
        if (fitsS(v)) return v[SAMPLE_W-1:0];
        return v[SW1-1] ? MINV : MAXV;
    endfunction

    logic w_m_clip, w_x_clip, r_ovf;

    assign w_m_re   = clampM(w_mre_div);
    assign w_m_im   = clampM(w_mim_div);
    assign w_m_clip = !fitsM(w_mre_div) || !fitsM(w_mim_div);
    assign w_x0_re  = clampS(w_x0_re_full);
    assign w_x0_im  = clampS(w_x0_im_full);
    assign w_x1_re  = clampS(w_x1_re_full);
    assign w_x1_im  = clampS(w_x1_im_full);
    assign w_x_clip = !fitsS(w_x0_re_full) || !fitsS(w_x0_im_full) ||
                      !fitsS(w_x1_re_full) || !fitsS(w_x1_im_full);
    assign ovf      = r_ovf;

    // Only clamps on real beats that are actually moving count; the clear wins
    // over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end else if (w_adv && ((r_v1 && w_m_clip) || (r_v2 && w_x_clip))) begin
            r_ovf <= 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_m_re   = w_mre_div[SAMPLE_W-1:0];
    assign w_m_im   = w_mim_div[SAMPLE_W-1:0];
    assign w_x0_re  = w_x0_re_full[SAMPLE_W-1:0];
    assign w_x0_im  = w_x0_im_full[SAMPLE_W-1:0];
    assign w_x1_re  = w_x1_re_full[SAMPLE_W-1:0];
    assign w_x1_im  = w_x1_im_full[SAMPLE_W-1:0];
    assign ovf      = 1'b0;
    // Bits discarded by wrapping, and the clear that has nothing to clear.
    assign w_unused = ^{ovf_clr, w_mre_div[FW-1:SAMPLE_W], w_mim_div[FW-1:SAMPLE_W],
                        w_x0_re_full[SAMPLE_W], w_x0_im_full[SAMPLE_W],
                        w_x1_re_full[SAMPLE_W], w_x1_im_full[SAMPLE_W]};
`endif

    // Stage 2 register: reduced twiddle product and a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_m_re  <= '0;
            r_m_im  <= '0;
            r_a2_re <= '0;
            r_a2_im <= '0;
        end else if (w_adv) begin
            r_v2    <= r_v1;
            r_m_re  <= w_m_re;
            r_m_im  <= w_m_im;
            r_a2_re <= r_a1_re;
            r_a2_im <= r_a1_im;
        end
    end

    // Stage 3 register: butterfly outputs, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3    <= 1'b0;
            r_x0_re <= '0;
            r_x0_im <= '0;
            r_x1_re <= '0;
            r_x1_im <= '0;
        end else if (w_adv) begin
            r_v3    <= r_v2;
            r_x0_re <= w_x0_re;
            r_x0_im <= w_x0_im;
            r_x1_re <= w_x1_re;
            r_x1_im <= w_x1_im;
        end
    end

endmodule
